// File: rtl/dshot_frame_receiver.sv
// dshot_frame_receiver: samples the DShot line, classifies pulses by high time and assembles 16-bit frames.
module dshot_frame_receiver #(
  parameter int THRESH_CYCLES   = 40,
  parameter int MIN_HIGH_CYCLES = 8,
  parameter int TIMEOUT_CYCLES  = 160
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dshot_in,
  output logic [15:0] raw_data,
  output logic        frame_valid,
  output logic        frame_error,
  output logic        busy
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] T_MAX = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] T_BIT = CW'(THRESH_CYCLES);
  localparam logic [CW-1:0] T_MIN = CW'(MIN_HIGH_CYCLES);
  localparam logic [1:0] IDLE = 2'd0, HIGH = 2'd1, LOW = 2'd2, STUCK = 2'd3;
  logic          sync_q, s_q, sd_q;
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] hi_cnt_q, hi_cnt_d, lo_cnt_q, lo_cnt_d;
  logic [4:0]    bit_cnt_q, bit_cnt_d;
  logic [15:0]   shreg_q, shreg_d, raw_q, raw_d, nbit;
  logic          valid_q, valid_d, error_q, error_d;
  logic          rise, fall;
  always_comb begin
    rise      = s_q & ~sd_q;
    fall      = ~s_q & sd_q;
    nbit      = {shreg_q[14:0], hi_cnt_q >= T_BIT};
    state_d   = state_q;
    hi_cnt_d  = rise ? CW'(1) : (s_q && hi_cnt_q != T_MAX) ? hi_cnt_q + CW'(1) : hi_cnt_q;
    lo_cnt_d  = lo_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    raw_d     = raw_q;
    valid_d   = 1'b0;
    error_d   = 1'b0;
    case (state_q)
      IDLE: if (rise) begin
        state_d   = HIGH;
        bit_cnt_d = 5'd0;
      end
      HIGH: if (fall) begin
        if (hi_cnt_q < T_MIN) begin
          error_d = 1'b1;
          state_d = IDLE;
        end else begin
          shreg_d   = nbit;
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd15) begin
            raw_d   = nbit;
            valid_d = 1'b1;
            state_d = IDLE;
          end else begin
            lo_cnt_d = CW'(1);
            state_d  = LOW;
          end
        end
      end else if (hi_cnt_q == T_MAX) begin
        error_d = 1'b1;
        state_d = STUCK;
      end
      LOW: if (rise) state_d = HIGH;
      else if (lo_cnt_q == T_MAX) begin
        error_d = 1'b1;
        state_d = IDLE;
      end else lo_cnt_d = lo_cnt_q + CW'(1);
      default: if (fall) state_d = IDLE;
    endcase
  end
  // sync chain resets high so a line already high at reset release is not a start
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q    <= 1'b1;
      s_q       <= 1'b1;
      sd_q      <= 1'b1;
      state_q   <= IDLE;
      hi_cnt_q  <= '0;
      lo_cnt_q  <= '0;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      raw_q     <= '0;
      valid_q   <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      sync_q    <= dshot_in;
      s_q       <= sync_q;
      sd_q      <= s_q;
      state_q   <= state_d;
      hi_cnt_q  <= hi_cnt_d;
      lo_cnt_q  <= lo_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      raw_q     <= raw_d;
      valid_q   <= valid_d;
      error_q   <= error_d;
    end
  end
  assign raw_data    = raw_q;
  assign frame_valid = valid_q;
  assign frame_error = error_q;
  assign busy        = state_q != IDLE;
endmodule

// File: tb/tb_dshot_frame_receiver.sv
// tb_dshot_frame_receiver: pulse-level reference model feeding a scoreboard checked by an output monitor.
module tb_dshot_frame_receiver;
  localparam int TH = 40, MINH = 8, TO = 160;
  typedef struct {logic err; logic [15:0] raw;} ev_t;
  logic clk, rst, dshot_in;
  logic [15:0] raw_data;
  logic frame_valid, frame_error, busy;
  int checks = 0, errors = 0;
  ev_t q[$];
  logic m_in = 1'b0;
  int m_bits = 0;
  logic [15:0] m_sh = '0, m_raw = '0;

  dshot_frame_receiver #(.THRESH_CYCLES(TH), .MIN_HIGH_CYCLES(MINH), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .dshot_in(dshot_in), .raw_data(raw_data),
    .frame_valid(frame_valid), .frame_error(frame_error), .busy(busy));

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  function automatic void push(logic e);
    ev_t x;
    x.err = e;
    x.raw = m_raw;
    q.push_back(x);
    m_in = 1'b0;
  endfunction

  // one pulse = h cycles high then l cycles low, judged by the frame rules
  function automatic void model_pulse(int h, int l);
    if (!m_in) begin
      m_in = 1'b1;
      m_bits = 0;
    end
    if (h > TO || h < MINH) push(1'b1);
    else begin
      m_sh = {m_sh[14:0], h >= TH};
      m_bits++;
      if (m_bits == 16) begin
        m_raw = m_sh;
        push(1'b0);
      end else if (l > TO) push(1'b1);
    end
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(int h, int l);
    model_pulse(h, l);
    dshot_in = 1'b1;
    repeat (h) @(negedge clk);
    dshot_in = 1'b0;
    repeat (l) @(negedge clk);
  endtask

  task automatic send_frame(logic [15:0] v, int h1, int h0, int lo, int last_low);
    for (int i = 15; i >= 0; i--) send(v[i] ? h1 : h0, i == 0 ? last_low : lo);
  endtask

  always @(negedge clk) if (!rst) begin
    if (frame_valid && frame_error) chk("valid_and_error", 1, 0);
    if (frame_valid || frame_error) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: valid=%0b error=%0b raw=%h", frame_valid, frame_error, raw_data);
      end else begin
        ev_t e;
        e = q.pop_front();
        if (frame_error !== e.err || raw_data !== e.raw) begin
          errors++;
          $display("FAIL event: got err=%0b raw=%h expected err=%0b raw=%h", frame_error, raw_data, e.err, e.raw);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    dshot_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_raw", raw_data, 0);
    chk("reset_flags", {frame_valid, frame_error, busy}, 0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    // 0xDEAD with exact latency on the last bit
    send_frame(16'hDEAD, 60, 30, 20, 0);
    repeat (2) @(negedge clk);
    chk("latency_before", frame_valid, 0);
    @(negedge clk);
    chk("latency_edge3", frame_valid, 1);
    chk("dead_raw", raw_data, 16'hDEAD);
    @(negedge clk);
    chk("valid_one_cycle", frame_valid, 0);
    repeat (50) @(negedge clk);
    // threshold boundaries
    send_frame(16'hAAAA, 40, 39, 30, 100);
    send_frame(16'hAAAA, 41, 38, 30, 100);
    send_frame(16'hDEAD, 60, 30, 20, 100);
    // glitch at bit 3 leaves raw_data alone
    send(60, 20); send(30, 50); send(60, 20);
    send(5, 200);
    send_frame(16'hBEEF, 60, 30, 20, 100);
    // low-gap timeout after 10 bits
    for (int i = 15; i >= 6; i--) send(16'h1234 >> i & 1 ? 60 : 30, i == 6 ? 300 : 20);
    chk("busy_after_gap_timeout", busy, 0);
    // stuck high
    model_pulse(500, 50);
    dshot_in = 1'b1;
    repeat (300) @(negedge clk);
    chk("busy_stuck", busy, 1);
    repeat (200) @(negedge clk);
    dshot_in = 1'b0;
    repeat (5) @(negedge clk);
    chk("idle_after_stuck", busy, 0);
    repeat (45) @(negedge clk);
    send_frame(16'h1234, 60, 30, 20, 100);
    // reset during bit 8 with the line high at release
    for (int i = 15; i >= 8; i--) send(16'h5A5A >> i & 1 ? 60 : 30, 20);
    dshot_in = 1'b1;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midreset_raw", raw_data, 0);
    chk("midreset_flags", {frame_valid, frame_error, busy}, 0);
    rst = 1'b0;
    m_in = 1'b0;
    m_raw = '0;
    repeat (30) @(negedge clk);
    dshot_in = 1'b0;
    repeat (20) @(negedge clk);
    for (int i = 6; i >= 0; i--) send(16'h5A5A >> i & 1 ? 60 : 30, i == 0 ? 300 : 20);
    send_frame(16'h1234, 60, 30, 20, 100);
    chk("raw_1234", raw_data, 16'h1234);
    // random frames, occasionally malformed
    for (int f = 0; f < 12; f++)
      for (int b = 0; b < 16; b++) begin
        int r, h, l;
        r = $urandom_range(0, 99);
        h = r < 2 ? $urandom_range(1, 7) : r < 3 ? $urandom_range(161, 170) : $urandom_range(8, 100);
        l = b == 15 ? 200 : ($urandom_range(0, 99) < 2 ? $urandom_range(161, 180) : $urandom_range(2, 60));
        send(h, l);
      end
    repeat (20) @(negedge clk);
    chk("scoreboard_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
